// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Results are latched on entry to DONE and held until the next completed division.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic             r_zero;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_dbz;

  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH-1:0] w_rem_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  // A restored remainder is always below the divisor, so only the shifted
  // value needs the extra bit; the difference always fits in WIDTH bits.
  assign w_rem_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_diff  = w_rem_shift[WIDTH-1:0] - r_divisor;
  assign w_rem_next  = w_ge ? w_rem_diff : w_rem_shift[WIDTH-1:0];
  assign w_q_next    = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A zero divisor loads a zero step count, so it leaves RUN after one clock.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_count == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_zero     <= 1'b0;
      r_quot     <= '0;
      r_remd     <= '0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_rem      <= '0;
            r_q        <= dividend;
            r_zero     <= (divisor == '0);
            r_count    <= (divisor == '0) ? '0 : CW'(WIDTH);
          end
        end
        S_RUN: begin
          if (r_count != '0) begin
            r_rem   <= w_rem_next;
            r_q     <= w_q_next;
            r_count <= r_count - 1'b1;
          end else begin
            r_quot <= r_zero ? '1 : r_q;
            r_remd <= r_zero ? r_dividend : r_rem;
            r_dbz  <= r_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remd;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
// Expected results are queued at issue and compared when done pulses.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_div(input logic [7:0] a, input logic [7:0] b, input bit expect_result);
    exp_t e;
    e.q = (b == 8'd0) ? 8'hFF : 8'(a / b);
    e.r = (b == 8'd0) ? a : 8'(a % b);
    e.z = (b == 8'd0);
    if (expect_result) sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  task automatic wait_done(output int lat, output bit held, output logic busy0);
    logic [7:0] q0;
    logic [7:0] r0;
    logic       z0;
    q0 = quotient; r0 = remainder; z0 = div_by_zero;
    held = 1'b1;
    lat  = -1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    for (int i = 1; i <= 30; i++) begin
      if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) held = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%0b exp=0", div_by_zero); end
  endtask

  task automatic test_basic();
    int lat; bit held; logic b0; exp_t e;
    start_div(8'd100, 8'd7, 1'b1);
    wait_done(lat, held, b0);
    e = sb.pop_front();
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got=%0b exp=1", b0); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (quotient !== e.q) begin errors++; $display("FAIL basic_q got=%0d exp=%0d", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("FAIL basic_r got=%0d exp=%0d", remainder, e.r); end
    checks++; if (div_by_zero !== e.z) begin errors++; $display("FAIL basic_dbz got=%0b exp=%0b", div_by_zero, e.z); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%0b done=%0b exp=0/0", busy, done); end
  endtask

  task automatic test_back_to_back();
    int lat; bit held; logic b0; exp_t e;
    start_div(8'd255, 8'd1, 1'b1);
    wait_done(lat, held, b0);
    e = sb.pop_front();
    checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL b2b_first got=%0d/%0d exp=%0d/%0d", quotient, remainder, e.q, e.r); end
    @(posedge clk); #1;
    start_div(8'd3, 8'd10, 1'b1);
    wait_done(lat, held, b0);
    e = sb.pop_front();
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold got=%0b exp=1", held); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency got=%0d exp=9", lat); end
    checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL b2b_second got=%0d/%0d exp=%0d/%0d", quotient, remainder, e.q, e.r); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat; bit held; logic b0; exp_t e;
    start_div(8'd5, 8'd0, 1'b1);
    wait_done(lat, held, b0);
    e = sb.pop_front();
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    checks++; if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin errors++; $display("FAIL dz_result got=%0d/%0d/%0b exp=%0d/%0d/%0b", quotient, remainder, div_by_zero, e.q, e.r, e.z); end
    @(posedge clk); #1;
    start_div(8'd8, 8'd2, 1'b1);
    wait_done(lat, held, b0);
    e = sb.pop_front();
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL dz_hold got=%0b exp=1", held); end
    checks++; if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin errors++; $display("FAIL dz_clear got=%0d/%0d/%0b exp=%0d/%0d/%0b", quotient, remainder, div_by_zero, e.q, e.r, e.z); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int ndone; int lat; exp_t e;
    ndone = 0; lat = -1;
    start_div(8'd200, 8'd9, 1'b1);
    @(posedge clk); #1;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 2) begin start = 1'b1; dividend = 8'd50; divisor = 8'd5; end
      if (i == 4) begin dividend = 8'hFF; divisor = 8'h01; end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat = i;
          e = sb.pop_front();
          checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL ign_result got=%0d/%0d exp=%0d/%0d", quotient, remainder, e.q, e.r); end
          start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        end
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL ign_latency got=%0d exp=9", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int ndone; int lat; bit held; logic b0; exp_t e;
    ndone = 0;
    start_div(8'd200, 8'd9, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_run_state got busy=%0b done=%0b exp=0/0", busy, done); end
    checks++; if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_run_outputs got=%0d/%0d/%0b exp=0/0/0", quotient, remainder, div_by_zero); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_run_no_done got=%0d exp=0", ndone); end
    start_div(8'd9, 8'd3, 1'b1);
    wait_done(lat, held, b0);
    e = sb.pop_front();
    checks++; if (quotient !== e.q || remainder !== e.r || lat !== 9) begin errors++; $display("FAIL rst_run_fresh got=%0d/%0d lat=%0d exp=%0d/%0d lat=9", quotient, remainder, lat, e.q, e.r); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; bit held; logic b0; exp_t e;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ta [6];
    logic [7:0] tb [6];
    ta = '{8'd0, 8'd0, 8'd13, 8'd255, 8'd255, 8'd1};
    tb = '{8'd7, 8'd0, 8'd13, 8'd255, 8'd0, 8'd255};
    for (int n = 0; n < 2000; n++) begin
      if (n < 6) begin
        a = ta[n]; b = tb[n];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      start_div(a, b, 1'b1);
      wait_done(lat, held, b0);
      e = sb.pop_front();
      checks++; if (lat !== ((b == 8'd0) ? 1 : 9)) begin errors++; $display("FAIL rnd_latency a=%0d b=%0d got=%0d exp=%0d", a, b, lat, (b == 8'd0) ? 1 : 9); end
      checks++; if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin errors++; $display("FAIL rnd_result a=%0d b=%0d got=%0d/%0d/%0b exp=%0d/%0d/%0b", a, b, quotient, remainder, div_by_zero, e.q, e.r, e.z); end
      if (b != 8'd0) begin
        checks++; if ((int'(quotient) * int'(b) + int'(remainder)) != int'(a) || remainder >= b) begin errors++; $display("FAIL rnd_identity a=%0d b=%0d got q=%0d r=%0d exp q*b+r=a, r<b", a, b, quotient, remainder); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
